// File: rtl/pipelined_adder_nbit_if.sv
// Handshake bundle for pipelined_adder_nbit: operand side (in_*/a/b/cin/sub)
// and result side (out_*/sum/cout, plus ovf when ADDER_OVF_EN is defined).
interface pipelined_adder_nbit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_adder_nbit.sv
// Pipelined add/subtract: STAGES registered chunks of WIDTH/STAGES bits.
// Ports: clk, rst_n (async active-low), io (slave modport: in_valid/in_ready,
// a, b, cin, sub, out_valid/out_ready, sum, cout; ovf if ADDER_OVF_EN).
module pipelined_adder_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_adder_nbit_if.slave io
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   free;

    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;

    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [STAGES-1:0] src_c;
    logic [CHUNK:0]    t;

`ifdef ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    // free[i]: slot i can take new data this cycle (empty or moving on).
    always_comb begin
        free         = '0;
        adv          = '0;
        load         = '0;
        v_d          = v_q;
        free[STAGES] = io.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i]  = v_q[i] & free[i+1];
            free[i] = !v_q[i] | adv[i];
        end
        load[0] = io.in_valid & free[0];
        for (int i = 1; i < STAGES; i++) begin
            load[i] = adv[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            v_d[i] = load[i] | (v_q[i] & !adv[i]);
        end
    end

    // Subtract folds into add: b inverted and carry-in inverted at entry.
    always_comb begin
        src_a[0] = io.a;
        src_b[0] = io.sub ? ~io.b : io.b;
        src_c[0] = io.sub ? ~io.cin : io.cin;
        src_s[0] = '0;
        for (int i = 1; i < STAGES; i++) begin
            src_a[i] = a_q[i-1];
            src_b[i] = b_q[i-1];
            src_c[i] = c_q[i-1];
            src_s[i] = s_q[i-1];
        end
        c_d = c_q;
        t   = '0;
        for (int i = 0; i < STAGES; i++) begin
            t = {1'b0, src_a[i][i*CHUNK +: CHUNK]}
              + {1'b0, src_b[i][i*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, src_c[i]};
            a_d[i] = a_q[i];
            b_d[i] = b_q[i];
            s_d[i] = s_q[i];
            if (load[i]) begin
                a_d[i] = src_a[i];
                b_d[i] = src_b[i];
                s_d[i] = src_s[i];
                s_d[i][i*CHUNK +: CHUNK] = t[CHUNK-1:0];
                c_d[i] = t[CHUNK];
            end
        end
`ifdef ADDER_OVF_EN
        // t still holds the last stage's chunk; a^b^s at the MSB is the carry into it.
        ovf_d = ovf_q;
        if (load[LAST]) begin
            ovf_d = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1]
                  ^ t[CHUNK-1] ^ t[CHUNK];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
            end
`ifdef ADDER_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
                s_q[i] <= s_d[i];
            end
`ifdef ADDER_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign io.in_ready  = free[0];
    assign io.out_valid = v_q[LAST];
    assign io.sum       = s_q[LAST];
    assign io.cout      = c_q[LAST];
`ifdef ADDER_OVF_EN
    assign io.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Directed bench for pipelined_adder_nbit (WIDTH=16, STAGES=4).
// Checks ovf too when ADDER_OVF_EN is defined.
module tb_pipelined_adder_nbit;
    localparam int W = 16;
    localparam int S = 4;
    localparam int N = 12;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t tbl [N];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_nbit_if #(.WIDTH(W)) bus ();

    pipelined_adder_nbit #(.WIDTH(W), .STAGES(S)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus)
    );

    int total = 0;
    int bad = 0;
    int exp_q [$];
    int accepted = 0;
    int cur = 0;
    int cyc = 0;
    logic [63:0] vhist;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic drive(input int k);
        bus.a   = tbl[k].a;
        bus.b   = tbl[k].b;
        bus.cin = tbl[k].cin;
        bus.sub = tbl[k].sub;
    endtask

    // One clock: sample at negedge, then step past the rising edge.
    task automatic cycle();
        int k;
        @(negedge clk);
        if (cyc < 64) vhist[cyc] = bus.out_valid;
        cyc++;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                k = exp_q.pop_front();
                chk($sformatf("sum[%0d]", k), 32'(bus.sum), 32'(tbl[k].s));
                chk($sformatf("cout[%0d]", k), 32'(bus.cout), 32'(tbl[k].co));
`ifdef ADDER_OVF_EN
                chk($sformatf("ovf[%0d]", k), 32'(bus.ovf), 32'(tbl[k].ov));
`endif
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(cur);
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        logic [W-1:0] held;
        logic [63:0] exp_mask;

        //           a        b        cin   sub   sum      co    ov
        tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{16'h1234, 16'h0235, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};
        tbl[2]  = '{16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
        tbl[6]  = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[7]  = '{16'h5000, 16'h1000, 1'b1, 1'b1, 16'h3FFF, 1'b1, 1'b0};
        tbl[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[10] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef ADDER_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single op latency
        cur = 0;
        drive(0);
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(S));
        cycle();

        // Back-to-back stream of the whole table
        cyc = 0;
        vhist = '0;
        for (int i = 0; i < N; i++) begin
            cur = i;
            drive(i);
            bus.in_valid = 1'b1;
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (8) cycle();
        exp_mask = '0;
        for (int i = S; i < S + N; i++) exp_mask[i] = 1'b1;
        chk("stream_valid_lo", vhist[31:0], exp_mask[31:0]);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Stall: hold in_valid with out_ready low
        bus.out_ready = 1'b0;
        accepted = 0;
        k = 0;
        repeat (7) begin
            cur = k;
            drive(k);
            bus.in_valid = 1'b1;
            n = accepted;
            cycle();
            if (accepted != n) k++;
        end
        chk("stall_accepted", 32'(accepted), 32'(S));
        @(negedge clk);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_sum", 32'(bus.sum), 32'(tbl[0].s));
        held = bus.sum;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_hold", 32'(bus.sum), 32'(held));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        #1;
        chk("full_pass_ready", 32'(bus.in_ready), 32'd1);
        n = 0;
        while (k < N && n < 40) begin
            cur = k;
            drive(k);
            bus.in_valid = 1'b1;
            accepted = 0;
            cycle();
            if (accepted != 0) k++;
            n++;
        end
        chk("refill_done", 32'(k), 32'(N));
        bus.in_valid = 1'b0;
        repeat (8) cycle();
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Reset with ops in flight
        for (int i = 0; i < 3; i++) begin
            cur = i;
            drive(i);
            bus.in_valid = 1'b1;
            cycle();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sum", 32'(bus.sum), 32'd0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        cyc = 0;
        vhist = '0;
        repeat (8) cycle();
        chk("no_stale", vhist[31:0], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
